// File: rtl/uart_core_cfg_if.sv
// Byte-side bus of uart_core_cfg: TX valid/ready handshake and RX result/acknowledge.
// master = register/bus front-end, slave = UART core.
interface uart_core_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;
  logic                 rx_ack;

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_core_cfg.sv
// Parametrised full-duplex UART (5..9 data bits, optional even/odd parity, 1/2 stop bits).
// Optional macro UART_LOOPBACK_EN adds a 'loopback' port routing internal tx into the RX path.
//
// state    | meaning (both FSMs)
// S_IDLE   | line idle, TX waits for handshake / RX waits for falling edge
// S_START  | start bit (RX: waiting for mid-start check)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only visited when PARITY_EN=1)
// S_STOP   | stop bit(s); RX samples only the first one
module uart_core_cfg #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_core_cfg_if.slave    bus,
  output logic              tx,
  output logic              tx_busy,
  input  logic              rx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(STOP_BITS * BIT_CLKS + 1);
  localparam int BITS_W   = $clog2(DATA_BITS + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [BITS_W-1:0] bcnt_t;

  localparam cnt_t  BIT_LOAD  = cnt_t'(BIT_CLKS - 1);
  localparam cnt_t  HALF_LOAD = cnt_t'(BIT_CLKS / 2 - 1);
  localparam cnt_t  STOP_LOAD = cnt_t'(STOP_BITS * BIT_CLKS - 1);
  localparam bcnt_t DATA_LAST = bcnt_t'(DATA_BITS - 1);
  localparam logic  PAR_ON    = (PARITY_EN != 0);
  localparam logic  PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t               tx_state_q;
  cnt_t                 tx_cnt_q;
  bcnt_t                tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (bus.tx_valid) begin
            tx_sh_q    <= bus.tx_data;
            tx_par_q   <= (^bus.tx_data) ^ PAR_ODD;
            tx_q       <= 1'b0;
            tx_cnt_q   <= BIT_LOAD;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == '0) begin
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_bit_q   <= DATA_LAST;
            tx_cnt_q   <= BIT_LOAD;
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - cnt_t'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt_q == '0) begin
            if (tx_bit_q == '0) begin
              if (PAR_ON) begin
                tx_q       <= tx_par_q;
                tx_cnt_q   <= BIT_LOAD;
                tx_state_q <= S_PARITY;
              end else begin
                tx_q       <= 1'b1;
                tx_cnt_q   <= STOP_LOAD;
                tx_state_q <= S_STOP;
              end
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q - bcnt_t'(1);
              tx_cnt_q <= BIT_LOAD;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - cnt_t'(1);
          end
        end
        S_PARITY: begin
          if (tx_cnt_q == '0) begin
            tx_q       <= 1'b1;
            tx_cnt_q   <= STOP_LOAD;
            tx_state_q <= S_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q - cnt_t'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt_q == '0) begin
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q - cnt_t'(1);
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- pad / loopback mux
  logic rx_src;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_q : rx;
  assign tx     = loopback ? 1'b1 : tx_q;
`else
  assign rx_src = rx;
  assign tx     = tx_q;
`endif

  assign tx_busy      = tx_busy_q;
  assign bus.tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- RX
  state_t               rx_state_q;
  cnt_t                 rx_cnt_q;
  bcnt_t                rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic                 rx_prev_q;
  logic                 rx_par_err_q;
  logic                 rx_valid_q;
  logic                 rx_frame_err_q;
  logic                 rx_parity_err_q;

  // Start detection needs a high-to-low transition, so a held-low break
  // line cannot retrigger reception until it has been seen high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q      <= S_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_sh_q         <= '0;
      rx_data_q       <= '0;
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_prev_q       <= 1'b1;
      rx_par_err_q    <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx_src;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_sync_q;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= HALF_LOAD;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              rx_state_q <= S_IDLE;
            end else begin
              rx_par_err_q <= 1'b0;
              rx_bit_q     <= DATA_LAST;
              rx_cnt_q     <= BIT_LOAD;
              rx_state_q   <= S_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - cnt_t'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_q <= BIT_LOAD;
            if (rx_bit_q == '0) begin
              rx_state_q <= PAR_ON ? S_PARITY : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q - bcnt_t'(1);
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - cnt_t'(1);
          end
        end
        S_PARITY: begin
          if (rx_cnt_q == '0) begin
            rx_par_err_q <= ((^rx_sh_q) ^ PAR_ODD) != rx_sync_q;
            rx_cnt_q     <= BIT_LOAD;
            rx_state_q   <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - cnt_t'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_valid_q      <= 1'b1;
            rx_data_q       <= rx_sh_q;
            rx_frame_err_q  <= !rx_sync_q;
            rx_parity_err_q <= rx_par_err_q & PAR_ON;
            rx_state_q      <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - cnt_t'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- overrun
  logic rx_pending_q;
  logic rx_overrun_q;

  // An ack coinciding with rx_valid acknowledges the new word itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pending_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else if (rx_valid_q) begin
      if (bus.rx_ack) begin
        rx_pending_q <= 1'b0;
        rx_overrun_q <= 1'b0;
      end else begin
        rx_pending_q <= 1'b1;
        if (rx_pending_q) begin
          rx_overrun_q <= 1'b1;
        end
      end
    end else if (bus.rx_ack) begin
      rx_pending_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_frame_err  = rx_frame_err_q;
  assign bus.rx_parity_err = rx_parity_err_q;
  assign bus.rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: an 8N1 instance and a 7E2 instance, BIT_CLKS=10.
module tb_uart_core_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  uart_core_cfg_if #(.DATA_BITS(8)) bus8 ();
  uart_core_cfg_if #(.DATA_BITS(7)) bus7 ();

  logic tx8, busy8, rx8;
  logic tx7, busy7, rx7;
`ifdef UART_LOOPBACK_EN
  logic lb8, lb7;
`endif

  uart_core_cfg #(
    .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
    .tx(tx8), .tx_busy(busy8), .rx(rx8)
`ifdef UART_LOOPBACK_EN
    , .loopback(lb8)
`endif
  );

  uart_core_cfg #(
    .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7.slave),
    .tx(tx7), .tx_busy(busy7), .rx(rx7)
`ifdef UART_LOOPBACK_EN
    , .loopback(lb7)
`endif
  );

  // receive-event monitors
  int         nv8 = 0;
  int         nv7 = 0;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       fe8, pe8, fe7, pe7;

  always @(posedge clk) begin
    if (bus8.rx_valid === 1'b1) begin
      nv8 <= nv8 + 1;
      d8  <= bus8.rx_data;
      fe8 <= bus8.rx_frame_err;
      pe8 <= bus8.rx_parity_err;
    end
    if (bus7.rx_valid === 1'b1) begin
      nv7 <= nv7 + 1;
      d7  <= bus7.rx_data;
      fe7 <= bus7.rx_frame_err;
      pe7 <= bus7.rx_parity_err;
    end
  end

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d, input logic p);
    return {5'b0, 2'b11, p, d, 1'b0};
  endfunction

  // drives n bits (LSB first) for 10 cycles each; call aligned to a negedge
  task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx8 = bits[i];
      else          rx7 = bits[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic idle_rx(input int sel, input int cycles);
    if (sel == 0) rx8 = 1'b1;
    else          rx7 = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_ack8;
    @(negedge clk);
    bus8.rx_ack = 1'b1;
    @(negedge clk);
    bus8.rx_ack = 1'b0;
  endtask

  // sends one byte on u8 and checks every line level at mid-bit plus tx_ready timing
  task automatic tx_frame_check(input logic [7:0] d);
    logic [9:0] exp_bits;
    logic [9:0] got;
    exp_bits = {1'b1, d, 1'b0};
    @(negedge clk);
    n_checks++;
    if (bus8.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_before: got %b want 1", bus8.tx_ready); end
    bus8.tx_data  = d;
    bus8.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus8.tx_valid = 1'b0;
    n_checks++;
    if (bus8.tx_ready !== 1'b0 || busy8 !== 1'b1) begin
      n_fail++; $display("FAIL tx_accept: ready=%b busy=%b want ready=0 busy=1", bus8.tx_ready, busy8);
    end
    repeat (5) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got[i] = tx8;
      n_checks++;
      if (tx8 !== exp_bits[i]) begin n_fail++; $display("FAIL tx_bit%0d (data %h): got %b want %b", i, d, tx8, exp_bits[i]); end
      if (i < 9) repeat (10) @(posedge clk);
    end
    n_checks++;
    if (got[8:1] !== d) begin n_fail++; $display("FAIL tx_decode: got %h want %h", got[8:1], d); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus8.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_cycle99: got %b want 0", bus8.tx_ready); end
    @(negedge clk);
    n_checks++;
    if (bus8.tx_ready !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL tx_ready_cycle100: ready=%b busy=%b want ready=1 busy=0", bus8.tx_ready, busy8);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (tx8 !== 1'b1 || bus8.tx_ready !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx: tx=%b ready=%b busy=%b want 1 1 0", tx8, bus8.tx_ready, busy8);
    end
    n_checks++;
    if (bus8.rx_valid !== 1'b0 || bus8.rx_frame_err !== 1'b0 || bus8.rx_parity_err !== 1'b0 || bus8.rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx_flags: v=%b fe=%b pe=%b ov=%b want 0000", bus8.rx_valid,
                         bus8.rx_frame_err, bus8.rx_parity_err, bus8.rx_overrun);
    end
    n_checks++;
    if (bus8.rx_data !== 8'h00 || bus7.rx_data !== 7'h00) begin
      n_fail++; $display("FAIL reset_rx_data: got %h/%h want 00/00", bus8.rx_data, bus7.rx_data);
    end
    n_checks++;
    if (tx7 !== 1'b1 || bus7.tx_ready !== 1'b1 || busy7 !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx7: tx=%b ready=%b busy=%b want 1 1 0", tx7, bus7.tx_ready, busy7);
    end
  endtask

  task automatic test_tx_8n1;
    tx_frame_check(8'hA5);
  endtask

  task automatic test_parity_7e2;
    int n0;
    n0 = nv7;
    @(negedge clk);
    drive_rx(1, frame7(7'h35, 1'b0), 11);
    idle_rx(1, 5);
    n_checks++;
    if (nv7 !== n0 + 1 || d7 !== 7'h35 || pe7 !== 1'b0 || fe7 !== 1'b0) begin
      n_fail++; $display("FAIL par_good: cnt=%0d data=%h pe=%b fe=%b want cnt=%0d data=35 pe=0 fe=0", nv7, d7, pe7, fe7, n0 + 1);
    end
    drive_rx(1, frame7(7'h35, 1'b1), 11);
    idle_rx(1, 5);
    n_checks++;
    if (nv7 !== n0 + 2 || d7 !== 7'h35 || pe7 !== 1'b1 || fe7 !== 1'b0) begin
      n_fail++; $display("FAIL par_bad: cnt=%0d data=%h pe=%b fe=%b want cnt=%0d data=35 pe=1 fe=0", nv7, d7, pe7, fe7, n0 + 2);
    end
  endtask

  task automatic test_frame_err_break;
    int n0;
    n0 = nv8;
    @(negedge clk);
    drive_rx(0, frame8(8'h3C, 1'b0), 10);
    n_checks++;
    if (nv8 !== n0 + 1 || d8 !== 8'h3C || fe8 !== 1'b1 || pe8 !== 1'b0) begin
      n_fail++; $display("FAIL frame_err: cnt=%0d data=%h fe=%b pe=%b want cnt=%0d data=3c fe=1 pe=0", nv8, d8, fe8, pe8, n0 + 1);
    end
    rx8 = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++;
    if (nv8 !== n0 + 1) begin n_fail++; $display("FAIL break_hold: cnt=%0d want %0d", nv8, n0 + 1); end
    idle_rx(0, 30);
    n_checks++;
    if (nv8 !== n0 + 1) begin n_fail++; $display("FAIL break_release: cnt=%0d want %0d", nv8, n0 + 1); end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = nv8;
    @(negedge clk);
    rx8 = 1'b0;
    repeat (3) @(negedge clk);
    idle_rx(0, 30);
    n_checks++;
    if (nv8 !== n0) begin n_fail++; $display("FAIL glitch: cnt=%0d want %0d", nv8, n0); end
    drive_rx(0, frame8(8'h55, 1'b1), 10);
    idle_rx(0, 5);
    n_checks++;
    if (nv8 !== n0 + 1 || d8 !== 8'h55 || fe8 !== 1'b0) begin
      n_fail++; $display("FAIL after_glitch: cnt=%0d data=%h fe=%b want cnt=%0d data=55 fe=0", nv8, d8, fe8, n0 + 1);
    end
  endtask

  task automatic test_overrun;
    int n0;
    pulse_ack8();
    @(negedge clk);
    n_checks++;
    if (bus8.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b want 0", bus8.rx_overrun); end
    n0 = nv8;
    drive_rx(0, frame8(8'h11, 1'b1), 10);
    n_checks++;
    if (bus8.rx_overrun !== 1'b0 || d8 !== 8'h11) begin
      n_fail++; $display("FAIL ovr_first: ov=%b data=%h want ov=0 data=11", bus8.rx_overrun, d8);
    end
    drive_rx(0, frame8(8'h22, 1'b1), 10);
    idle_rx(0, 5);
    n_checks++;
    if (bus8.rx_overrun !== 1'b1 || d8 !== 8'h22 || nv8 !== n0 + 2) begin
      n_fail++; $display("FAIL ovr_second: ov=%b data=%h cnt=%0d want ov=1 data=22 cnt=%0d", bus8.rx_overrun, d8, nv8, n0 + 2);
    end
    pulse_ack8();
    n_checks++;
    if (bus8.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: got %b want 0", bus8.rx_overrun); end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    bus8.tx_data  = 8'hF0;
    bus8.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus8.tx_valid = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx8 !== 1'b1 || bus8.tx_ready !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: tx=%b ready=%b busy=%b want 1 1 0", tx8, bus8.tx_ready, busy8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_frame_check(8'h0F);
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    int   n0;
    logic pin_low;
    n0 = nv8;
    pin_low = 1'b0;
    @(negedge clk);
    lb8 = 1'b1;
    bus8.tx_data  = 8'hC3;
    bus8.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus8.tx_valid = 1'b0;
    for (int i = 0; i < 115; i++) begin
      @(negedge clk);
      if (tx8 !== 1'b1) pin_low = 1'b1;
    end
    n_checks++;
    if (pin_low !== 1'b0) begin n_fail++; $display("FAIL lb_pin: pin went low=%b want 0", pin_low); end
    n_checks++;
    if (nv8 !== n0 + 1 || d8 !== 8'hC3 || fe8 !== 1'b0) begin
      n_fail++; $display("FAIL lb_rx: cnt=%0d data=%h fe=%b want cnt=%0d data=c3 fe=0", nv8, d8, fe8, n0 + 1);
    end
    lb8 = 1'b0;
  endtask
`endif

  initial begin
    rx8 = 1'b1;
    rx7 = 1'b1;
    bus8.tx_data = '0; bus8.tx_valid = 1'b0; bus8.rx_ack = 1'b0;
    bus7.tx_data = '0; bus7.tx_valid = 1'b0; bus7.rx_ack = 1'b0;
`ifdef UART_LOOPBACK_EN
    lb8 = 1'b0;
    lb7 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_tx_8n1();
    test_parity_7e2();
    test_frame_err_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
- Parametrised full-duplex UART core; the next generation of the team's fixed 8N1 transmitter/receiver pair.
- Supports configurable data width, optional even/odd parity, and 1 or 2 stop bits.
- TX side uses a valid/ready handshake. RX side validates the start bit and reports framing, parity and overrun errors.
- Sits between a register/bus front-end and the chip pads.

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. BIT_CLKS = CLK_FREQ/BAUD_RATE (integer division). BIT_CLKS must be >= 4.
- DATA_BITS, 8, payload bits per frame, legal range 5..9, LSB sent first.
- PARITY_EN, 0, 1 = one parity bit is inserted after the data bits.
- PARITY_ODD, 0, when PARITY_EN=1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a frame.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  a frame is on the line.
- rx  in  1  serial input, asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- rx_frame_err  out  1  one-cycle pulse together with rx_valid when the first stop bit sampled 0.
- rx_parity_err  out  1  one-cycle pulse together with rx_valid on parity mismatch; always 0 when PARITY_EN=0.
- rx_overrun  out  1  sticky flag, set when a new rx_valid fires while rx_ack has not been seen since the previous one.
- rx_ack  in  1  consumer acknowledge; clears the pending flag and rx_overrun.

Behaviour:
Reset (rst_n=0, takes effect immediately):
- Outputs: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_data=0.
- Both FSMs go to IDLE and all counters clear. Reset mid-frame abandons the frame with no error pulse.

RX input synchronisation:
- rx passes through a 2-flop synchroniser with reset value 1. All RX decisions use the synchronised signal.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- The handshake completes when tx_valid && tx_ready on a rising edge. tx_data is captured into a shift register and the FSM moves to START. tx_ready drops the next cycle.
- Each state holds tx for exactly BIT_CLKS cycles. tx changes on the cycle after the handshake (start bit = 0).
- DATA shifts out DATA_BITS bits, LSB first. PARITY is skipped if PARITY_EN=0. STOP drives 1 for STOP_BITS*BIT_CLKS cycles.
- tx_ready rises on the cycle after the last stop-bit cycle. Back-to-back frames therefore have no idle gap.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS)*BIT_CLKS cycles.
- tx_busy = 1 in every state except IDLE.
- Parity = XOR of the data bits, inverted when PARITY_ODD=1.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: a falling edge on the synchronised rx moves the FSM to START and loads the counter for BIT_CLKS/2.
- At mid-start the line is checked. If rx=1 the start is false: return to IDLE with no pulse.
- If the start is valid, sample every BIT_CLKS cycles: DATA_BITS data bits (LSB first), the parity bit if enabled, then the first stop bit only.
- The stop-bit sample cycle drives rx_valid=1 and updates rx_data, with the error pulses on the same cycle. The FSM returns to IDLE on that cycle.
- The second stop bit is not checked. This permits resynchronisation on the next start edge.
- A frame error with rx held low (break) does not restart reception until rx has been seen high.

Overrun:
- An internal pending flag sets on rx_valid and clears on rx_ack.
- rx_ack asserted in the same cycle as rx_valid acknowledges the new data, so no overrun is raised.

Independence:
- TX and RX are fully independent and may be active simultaneously.

Optional Feature:
UART_LOOPBACK_EN:
- When defined, a port loopback (in, 1) is added. When loopback=1, the RX synchroniser input is taken from the internal tx signal instead of the rx pin. The tx pin is then held at 1 (idle).
- When undefined, the port does not exist and RX always uses the rx pin.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (BIT_CLKS=10) unless stated otherwise.
1. 8N1: send 0xA5 -> tx line sequence 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. tx_ready returns after 100 cycles. The external RX model decodes 0xA5.
2. 7E2 (DATA_BITS=7, PARITY_EN=1, STOP_BITS=2): drive the rx frame for 0x35 with parity bit 0 -> rx_valid with rx_data=0x35, rx_parity_err=0. Repeat with parity bit 1 -> rx_parity_err=1.
3. Drive a frame for 0x3C with the stop bit forced to 0 -> rx_valid and rx_frame_err=1, rx_data=0x3C. Then hold rx low for 200 cycles -> no further rx_valid until rx returns high.
4. Drive a 3-cycle low glitch on idle rx -> no rx_valid. Next, send a valid 0x55 frame -> received correctly.
5. Receive 0x11 and 0x22 back-to-back with no rx_ack -> rx_overrun=1 after the second frame and rx_data=0x22. Pulse rx_ack -> rx_overrun=0.
6. Assert rst_n=0 mid-way through the TX data bits -> tx=1 and tx_ready=1 immediately. After release, sending 0x0F works normally. With UART_LOOPBACK_EN and loopback=1, sending 0xC3 -> rx_valid with rx_data=0xC3 and the tx pin held at 1.
